// File: rtl/scan_decoder.sv
// SEL_W-to-2^SEL_W decoder with 74138-style enables and registered active-low outputs.
// Supports direct decode of select_i or an automatic scan with a programmable dwell and a blanking gap.
module scan_decoder #(
    parameter int SEL_W        = 3,
    parameter int DWELL_W      = 8,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  g1_en_i,
    input  logic                  g2a_en_n_i,
    input  logic                  g2b_en_n_i,
    input  logic                  mode_i,
    input  logic [SEL_W-1:0]      select_i,
    input  logic [DWELL_W-1:0]    dwell_i,
    output logic [2**SEL_W-1:0]   yn_o,
    output logic [SEL_W-1:0]      active_idx_o,
    output logic                  wrap_o
);
    localparam int OUT_N   = 2**SEL_W;
    localparam int BLANK_W = $clog2(BLANK_CYCLES + 2);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN_ON, SCAN_BLANK} state_t;

    state_t             state_q, state_d;
    logic [OUT_N-1:0]   yn_d;
    logic [SEL_W-1:0]   idx_d, idx_inc;
    logic               wrap_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d, dwell_load;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
    logic               en;

    function automatic logic [OUT_N-1:0] decode_n(input logic [SEL_W-1:0] idx);
        decode_n = ~(OUT_N'(1) << idx);
    endfunction

    assign en         = g1_en_i & ~g2a_en_n_i & ~g2b_en_n_i;
    assign dwell_load = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;
    // Index arithmetic wraps naturally at SEL_W bits, i.e. modulo OUT_N.
    assign idx_inc    = active_idx_o + SEL_W'(1);

    always_comb begin
        state_d     = state_q;
        yn_d        = yn_o;
        idx_d       = active_idx_o;
        wrap_d      = 1'b0;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;
        if (!en) begin
            state_d     = IDLE;
            yn_d        = '1;
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
        end else if (!mode_i) begin
            state_d = DIRECT;
            yn_d    = decode_n(select_i);
            idx_d   = select_i;
        end else begin
            case (state_q)
                SCAN_ON: begin
                    if (dwell_cnt_q > DWELL_W'(1)) begin
                        dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                    end else if (BLANK_CYCLES > 0) begin
                        state_d     = SCAN_BLANK;
                        yn_d        = '1;
                        blank_cnt_d = BLANK_W'(BLANK_CYCLES);
                    end else begin
                        yn_d        = decode_n(idx_inc);
                        idx_d       = idx_inc;
                        dwell_cnt_d = dwell_load;
                        wrap_d      = (idx_inc == '0);
                    end
                end
                SCAN_BLANK: begin
                    if (blank_cnt_q > BLANK_W'(1)) begin
                        blank_cnt_d = blank_cnt_q - BLANK_W'(1);
                    end else begin
                        state_d     = SCAN_ON;
                        yn_d        = decode_n(idx_inc);
                        idx_d       = idx_inc;
                        dwell_cnt_d = dwell_load;
                        wrap_d      = (idx_inc == '0);
                    end
                end
                // Entry from IDLE or DIRECT always restarts at index 0 with no wrap.
                default: begin
                    state_d     = SCAN_ON;
                    yn_d        = decode_n('0);
                    idx_d       = '0;
                    dwell_cnt_d = dwell_load;
                    blank_cnt_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            yn_o         <= '1;
            active_idx_o <= '0;
            wrap_o       <= 1'b0;
            dwell_cnt_q  <= '0;
            blank_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            yn_o         <= yn_d;
            active_idx_o <= idx_d;
            wrap_o       <= wrap_d;
            dwell_cnt_q  <= dwell_cnt_d;
            blank_cnt_q  <= blank_cnt_d;
        end
    end
endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: two instances (blank gap of 1 and of 0) share stimulus and
// are checked against a slot-schedule queue model plus directed expected sequences.
module tb_scan_decoder;
    localparam int OUT_N = 8;

    logic       clk = 1'b0, rst = 1'b0, g1 = 1'b0, g2a = 1'b1, g2b = 1'b1, mode = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] dwell = '0;
    logic [7:0] yn_b, yn_z;
    logic [2:0] idx_b, idx_z;
    logic       wrap_b, wrap_z;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    scan_decoder #(.SEL_W(3), .DWELL_W(8), .BLANK_CYCLES(1)) dut_b (
        .clk_i(clk), .rst_i(rst), .g1_en_i(g1), .g2a_en_n_i(g2a), .g2b_en_n_i(g2b),
        .mode_i(mode), .select_i(sel), .dwell_i(dwell),
        .yn_o(yn_b), .active_idx_o(idx_b), .wrap_o(wrap_b));

    scan_decoder #(.SEL_W(3), .DWELL_W(8), .BLANK_CYCLES(0)) dut_z (
        .clk_i(clk), .rst_i(rst), .g1_en_i(g1), .g2a_en_n_i(g2a), .g2b_en_n_i(g2b),
        .mode_i(mode), .select_i(sel), .dwell_i(dwell),
        .yn_o(yn_z), .active_idx_o(idx_z), .wrap_o(wrap_z));

    // Model: on entering a scan slot, the whole slot (dwell entries plus blank entries)
    // is scheduled into a queue and then replayed one entry per clock.
    typedef struct {logic [7:0] yn; logic [2:0] idx; logic wrap;} ent_t;
    ent_t       mq[2][$];
    logic [7:0] m_yn[2];
    logic [2:0] m_idx[2];
    logic       m_wrap[2];
    bit         m_scan[2];
    bit         m_first[2];
    int         m_next[2];

    task automatic model_edge();
        bit   en;
        int   d;
        ent_t e;
        en = g1 && !g2a && !g2b;
        for (int k = 0; k < 2; k++) begin
            m_wrap[k] = 1'b0;
            if (rst) begin
                mq[k].delete(); m_yn[k] = 8'hFF; m_idx[k] = 3'd0; m_scan[k] = 0;
            end else if (!en) begin
                mq[k].delete(); m_yn[k] = 8'hFF; m_scan[k] = 0;
            end else if (!mode) begin
                mq[k].delete(); m_yn[k] = ~(8'd1 << sel); m_idx[k] = sel; m_scan[k] = 0;
            end else begin
                if (!m_scan[k]) begin
                    m_scan[k] = 1; m_next[k] = 0; m_first[k] = 1; mq[k].delete();
                end
                if (mq[k].size() == 0) begin
                    d = (dwell == 8'd0) ? 1 : int'(dwell);
                    for (int i = 0; i < d; i++)
                        mq[k].push_back('{~(8'd1 << m_next[k]), 3'(m_next[k]),
                                          (i == 0 && m_next[k] == 0 && !m_first[k])});
                    for (int i = 0; i < (k == 0 ? 1 : 0); i++)
                        mq[k].push_back('{8'hFF, 3'(m_next[k]), 1'b0});
                    m_first[k] = 0;
                    m_next[k]  = (m_next[k] + 1) % OUT_N;
                end
                e = mq[k].pop_front();
                m_yn[k] = e.yn; m_idx[k] = e.idx; m_wrap[k] = e.wrap;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_en(input bit on);
        g1 = on; g2a = !on; g2b = !on;
    endtask

    task automatic test_reset();
        set_en(1); mode = 1'b1; dwell = 8'd2; rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            checks++;
            if (yn_b !== 8'hFF || idx_b !== 3'd0 || wrap_b !== 1'b0)
                begin errors++; $display("FAIL reset_b c=%0d yn=%h idx=%0d wrap=%b exp FF/0/0", c, yn_b, idx_b, wrap_b); end
            checks++;
            if (yn_z !== 8'hFF || idx_z !== 3'd0 || wrap_z !== 1'b0)
                begin errors++; $display("FAIL reset_z c=%0d yn=%h idx=%0d wrap=%b exp FF/0/0", c, yn_z, idx_z, wrap_z); end
        end
        rst = 1'b0; set_en(0); tick();
    endtask

    task automatic test_direct();
        logic [7:0] exp_v[3] = '{8'hDF, 8'hFB, 8'hFF};
        set_en(1); mode = 1'b0; sel = 3'd5;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (yn_b !== exp_v[c] || yn_z !== exp_v[c])
                begin errors++; $display("FAIL direct_step%0d yn_b=%h yn_z=%h exp=%h", c, yn_b, yn_z, exp_v[c]); end
            if (c == 0) sel = 3'd2;
            if (c == 1) g2a = 1'b1;
        end
        checks++;
        if (idx_b !== 3'd2)
            begin errors++; $display("FAIL direct_idx_hold idx=%0d exp=2", idx_b); end
        for (int c = 0; c < 24; c++) begin
            set_en(1); g2b = ($urandom_range(0, 5) == 0); sel = 3'($urandom);
            tick();
            checks++;
            if (yn_b !== m_yn[0] || idx_b !== m_idx[0] || wrap_b !== 1'b0)
                begin errors++; $display("FAIL direct_rand yn=%h idx=%0d wrap=%b exp %h/%0d/0", yn_b, idx_b, wrap_b, m_yn[0], m_idx[0]); end
        end
        set_en(0); tick();
    endtask

    task automatic test_scan_gap();
        logic [7:0] e;
        dwell = 8'd2; mode = 1'b1; set_en(1);
        for (int n = 0; n < 25; n++) begin
            tick();
            e = (n % 3 < 2) ? ~(8'd1 << ((n / 3) % 8)) : 8'hFF;
            checks++;
            if (yn_b !== e || wrap_b !== (n == 24))
                begin errors++; $display("FAIL scan_gap n=%0d yn=%h wrap=%b exp %h/%b", n, yn_b, wrap_b, e, n == 24); end
            checks++;
            if (yn_z !== m_yn[1] || wrap_z !== m_wrap[1])
                begin errors++; $display("FAIL scan_gap_z n=%0d yn=%h wrap=%b exp %h/%b", n, yn_z, wrap_z, m_yn[1], m_wrap[1]); end
        end
        set_en(0); tick();
    endtask

    task automatic test_scan_nogap();
        logic [7:0] e;
        dwell = 8'd0; mode = 1'b1; set_en(1);
        for (int n = 0; n < 17; n++) begin
            tick();
            e = ~(8'd1 << (n % 8));
            checks++;
            if (yn_z !== e || idx_z !== 3'(n % 8) || wrap_z !== (n == 8 || n == 16))
                begin errors++; $display("FAIL scan_nogap n=%0d yn=%h idx=%0d wrap=%b exp %h", n, yn_z, idx_z, wrap_z, e); end
        end
        set_en(0); tick();
    endtask

    task automatic test_disable();
        dwell = 8'd3; mode = 1'b1; set_en(1);
        repeat (13) tick();
        checks++;
        if (yn_b !== 8'hF7 || idx_b !== 3'd3)
            begin errors++; $display("FAIL disable_pre yn=%h idx=%0d exp F7/3", yn_b, idx_b); end
        g1 = 1'b0; tick();
        checks++;
        if (yn_b !== 8'hFF || wrap_b !== 1'b0 || idx_b !== 3'd3)
            begin errors++; $display("FAIL disable_off yn=%h idx=%0d exp FF/3", yn_b, idx_b); end
        g1 = 1'b1; tick();
        checks++;
        if (yn_b !== 8'hFE || wrap_b !== 1'b0 || yn_z !== 8'hFE || wrap_z !== 1'b0)
            begin errors++; $display("FAIL disable_reen yn_b=%h yn_z=%h wrap=%b%b exp FE/0", yn_b, yn_z, wrap_b, wrap_z); end
        set_en(0); tick();
    endtask

    task automatic test_mode_reset();
        dwell = 8'd2; mode = 1'b1; set_en(1);
        repeat (13) tick();
        checks++;
        if (yn_b !== 8'hEF)
            begin errors++; $display("FAIL mode_pre yn=%h exp EF", yn_b); end
        mode = 1'b0; sel = 3'd1; tick();
        checks++;
        if (yn_b !== 8'hFD || idx_b !== 3'd1)
            begin errors++; $display("FAIL mode_direct yn=%h idx=%0d exp FD/1", yn_b, idx_b); end
        mode = 1'b1; tick();
        checks++;
        if (yn_b !== 8'hFE || wrap_b !== 1'b0)
            begin errors++; $display("FAIL mode_rescan yn=%h wrap=%b exp FE/0", yn_b, wrap_b); end
        tick(); rst = 1'b1; tick();
        checks++;
        if (yn_b !== 8'hFF || idx_b !== 3'd0)
            begin errors++; $display("FAIL mode_rst yn=%h idx=%0d exp FF/0", yn_b, idx_b); end
        rst = 1'b0; tick();
        checks++;
        if (yn_b !== 8'hFE || wrap_b !== 1'b0)
            begin errors++; $display("FAIL mode_release yn=%h wrap=%b exp FE/0", yn_b, wrap_b); end
    endtask

    task automatic test_random();
        logic [7:0] y;
        logic [2:0] ix;
        logic       w;
        for (int n = 0; n < 400; n++) begin
            rst  = ($urandom_range(0, 59) == 0);
            g1   = ($urandom_range(0, 14) != 0);
            g2a  = ($urandom_range(0, 19) == 0);
            g2b  = ($urandom_range(0, 19) == 0);
            mode = ($urandom_range(0, 9) != 0);
            sel  = 3'($urandom);
            if ($urandom_range(0, 3) == 0) dwell = 8'($urandom_range(0, 4));
            tick();
            for (int k = 0; k < 2; k++) begin
                y = k ? yn_z : yn_b; ix = k ? idx_z : idx_b; w = k ? wrap_z : wrap_b;
                checks++;
                if (y !== m_yn[k] || ix !== m_idx[k] || w !== m_wrap[k])
                    begin errors++; $display("FAIL random k=%0d n=%0d yn=%h idx=%0d wrap=%b exp %h/%0d/%b", k, n, y, ix, w, m_yn[k], m_idx[k], m_wrap[k]); end
                checks++;
                if ($countones(~y) > 1)
                    begin errors++; $display("FAIL onehot k=%0d n=%0d yn=%h exp at most one low", k, n, y); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_direct();
        test_scan_gap();
        test_scan_nogap();
        test_disable();
        test_mode_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
